// File: rtl/miriscv_hazard_ctrl_if.sv
// rtl/miriscv_hazard_ctrl_if.sv - decoder/retire/issue signal bundle for the miriscv hazard controller
interface miriscv_hazard_ctrl_if #(
    parameter int LSU_DEPTH = 2
);
    localparam int PCNT_W = $clog2(LSU_DEPTH + 1);

    logic              dec_valid_i;
    logic [4:0]        dec_rs1_addr_i;
    logic [4:0]        dec_rs2_addr_i;
    logic              dec_rs1_re_i;
    logic              dec_rs2_re_i;
    logic [4:0]        dec_rd_addr_i;
    logic              dec_wb_we_i;
    logic              dec_load_i;
    logic              dec_mdu_req_i;
    logic              dec_fence_i;
    logic              flush_i;
    logic              lsu_rsp_valid_i;
    logic              mdu_done_i;
    logic              stall_o;
    logic              issue_o;
    logic [4:0]        lsu_rsp_rd_o;
    logic [4:0]        mdu_rd_o;
    logic              mdu_busy_o;
    logic [PCNT_W-1:0] pending_loads_o;
    logic [31:0]       scoreboard_o;
    logic              spurious_rsp_o;

    modport master (
        output dec_valid_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_rs1_re_i, dec_rs2_re_i,
               dec_rd_addr_i, dec_wb_we_i, dec_load_i, dec_mdu_req_i, dec_fence_i,
               flush_i, lsu_rsp_valid_i, mdu_done_i,
        input  stall_o, issue_o, lsu_rsp_rd_o, mdu_rd_o, mdu_busy_o, pending_loads_o,
               scoreboard_o, spurious_rsp_o
    );

    modport slave (
        input  dec_valid_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_rs1_re_i, dec_rs2_re_i,
               dec_rd_addr_i, dec_wb_we_i, dec_load_i, dec_mdu_req_i, dec_fence_i,
               flush_i, lsu_rsp_valid_i, mdu_done_i,
        output stall_o, issue_o, lsu_rsp_rd_o, mdu_rd_o, mdu_busy_o, pending_loads_o,
               scoreboard_o, spurious_rsp_o
    );
endinterface

// File: rtl/miriscv_hazard_ctrl.sv
// rtl/miriscv_hazard_ctrl.sv - issue-stage scoreboard and stall logic; MIRISCV_HAZARD_BYPASS_EN enables same-cycle retire bypass
module miriscv_hazard_ctrl #(
    parameter int LSU_DEPTH = 2
) (
    input logic                   clk_i,
    input logic                   arstn_i,
    miriscv_hazard_ctrl_if.slave  hz
);
    localparam int PCNT_W = $clog2(LSU_DEPTH + 1);
    localparam int PTR_W  = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(LSU_DEPTH - 1);
    localparam logic [PCNT_W-1:0] CNT_FULL = PCNT_W'(LSU_DEPTH);

    logic [31:0]       sb_q, sb_d, set_mask, clr_mask, sb_haz;
    logic [4:0]        tag_q [LSU_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PCNT_W-1:0] cnt_q, cnt_haz;
    logic              mdu_busy_q, mdu_busy_haz;
    logic [4:0]        mdu_rd_q;
    logic              spurious_q;
    logic              fifo_empty, fifo_full, pop, push, mdu_retire, mdu_issue;
    logic              raw, waw, load_res, mdu_res, fence_drain, stall, issue;
    logic [4:0]        head_tag, push_tag;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_FULL);
    assign head_tag   = fifo_empty ? 5'd0 : tag_q[rd_ptr_q];
    assign pop        = hz.lsu_rsp_valid_i && !fifo_empty;
    assign mdu_retire = hz.mdu_done_i && mdu_busy_q;

    always_comb begin
        clr_mask = '0;
        if (pop)        clr_mask[head_tag] = 1'b1;
        if (mdu_retire) clr_mask[mdu_rd_q] = 1'b1;
        clr_mask[0] = 1'b0;
    end

`ifdef MIRISCV_HAZARD_BYPASS_EN
    // Retiring producers are invisible to RAW/fence checks; the regfile forwards the result.
    assign sb_haz       = sb_q & ~clr_mask;
    assign cnt_haz      = cnt_q - PCNT_W'(pop);
    assign mdu_busy_haz = mdu_busy_q && !mdu_retire;
`else
    assign sb_haz       = sb_q;
    assign cnt_haz      = cnt_q;
    assign mdu_busy_haz = mdu_busy_q;
`endif

    always_comb begin
        raw = (hz.dec_rs1_re_i && (hz.dec_rs1_addr_i != 5'd0) && sb_haz[hz.dec_rs1_addr_i]) ||
              (hz.dec_rs2_re_i && (hz.dec_rs2_addr_i != 5'd0) && sb_haz[hz.dec_rs2_addr_i]);
        waw         = hz.dec_wb_we_i && (hz.dec_rd_addr_i != 5'd0) && sb_q[hz.dec_rd_addr_i];
        load_res    = hz.dec_load_i && fifo_full;
        mdu_res     = hz.dec_mdu_req_i && mdu_busy_q;
        fence_drain = hz.dec_fence_i && ((cnt_haz != '0) || mdu_busy_haz);
        stall       = hz.dec_valid_i && (raw || waw || load_res || mdu_res || fence_drain);
        issue       = hz.dec_valid_i && !stall && !hz.flush_i;
    end

    assign push      = issue && hz.dec_load_i;
    assign mdu_issue = issue && hz.dec_mdu_req_i;
    assign push_tag  = hz.dec_wb_we_i ? hz.dec_rd_addr_i : 5'd0;

    // Clear before set so a retiring bit can be reclaimed by the issuing instruction.
    always_comb begin
        set_mask = '0;
        if ((push || mdu_issue) && hz.dec_wb_we_i && (hz.dec_rd_addr_i != 5'd0))
            set_mask[hz.dec_rd_addr_i] = 1'b1;
        sb_d    = (sb_q & ~clr_mask) | set_mask;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sb_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            mdu_busy_q <= 1'b0;
            mdu_rd_q   <= 5'd0;
            spurious_q <= 1'b0;
            for (int i = 0; i < LSU_DEPTH; i++) tag_q[i] <= 5'd0;
        end else begin
            sb_q <= sb_d;
            if (push) begin
                tag_q[wr_ptr_q] <= push_tag;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      cnt_q <= cnt_q + PCNT_W'(1);
            else if (pop && !push) cnt_q <= cnt_q - PCNT_W'(1);
            if (mdu_retire) mdu_busy_q <= 1'b0;
            if (mdu_issue) begin
                mdu_busy_q <= 1'b1;
                mdu_rd_q   <= hz.dec_rd_addr_i;
            end
            spurious_q <= (hz.lsu_rsp_valid_i && fifo_empty) || (hz.mdu_done_i && !mdu_busy_q);
        end
    end

    assign hz.stall_o         = stall;
    assign hz.issue_o         = issue;
    assign hz.lsu_rsp_rd_o    = head_tag;
    assign hz.mdu_rd_o        = mdu_rd_q;
    assign hz.mdu_busy_o      = mdu_busy_q;
    assign hz.pending_loads_o = cnt_q;
    assign hz.scoreboard_o    = sb_q;
    assign hz.spurious_rsp_o  = spurious_q;
endmodule

// File: doc/miriscv_hazard_ctrl.md
Name: miriscv_hazard_ctrl

Overview:
Issue-stage hazard controller and scoreboard for the miriscv core. It sits between the decoder and execute. It consumes the decoder's register-read, writeback, load, MDU and fence indications, tracks destination registers of in-flight long-latency operations (loads, MDU), and stalls issue on RAW/WAW conflicts, resource exhaustion, or fence drain. Load destinations are held in an in-order tag FIFO popped by LSU responses.

Parameters:
LSU_DEPTH, 2, max outstanding loads (tag FIFO depth), legal range 1..8
PCNT_W, $clog2(LSU_DEPTH+1), width of pending-load counter (derived, not overridable)

Ports:
clk_i  in  1  core clock
arstn_i  in  1  asynchronous active-low reset
dec_valid_i  in  1  decoded instruction present in issue stage
dec_rs1_addr_i  in  5  rs1 index
dec_rs2_addr_i  in  5  rs2 index
dec_rs1_re_i  in  1  rs1 read enable (from decoder)
dec_rs2_re_i  in  1  rs2 read enable
dec_rd_addr_i  in  5  rd index
dec_wb_we_i  in  1  instruction writes rd
dec_load_i  in  1  instruction is a load
dec_mdu_req_i  in  1  instruction uses MDU
dec_fence_i  in  1  instruction is a fence
flush_i  in  1  kill instruction in issue stage this cycle
lsu_rsp_valid_i  in  1  load data returned (in order), one per cycle max
mdu_done_i  in  1  MDU result valid this cycle
stall_o  out  1  hold issue stage
issue_o  out  1  instruction accepted into execute this cycle
lsu_rsp_rd_o  out  5  rd tag of FIFO head (valid with lsu_rsp_valid_i)
mdu_rd_o  out  5  rd of in-flight MDU op
mdu_busy_o  out  1  MDU op outstanding
pending_loads_o  out  PCNT_W  FIFO occupancy
scoreboard_o  out  32  pending-write bitmap; bit 0 always 0
spurious_rsp_o  out  1  one-cycle pulse: response with nothing outstanding

Behaviour:
- Reset (arstn_i low, asynchronous): scoreboard=0, FIFO empty, pending_loads_o=0, mdu_busy_o=0, mdu_rd_o=0, spurious_rsp_o=0. stall_o and issue_o are combinational and evaluate to 0 while dec_valid_i=0.
- Reset mid-operation discards all in-flight tags. Responses arriving after reset are treated as spurious.
- Stall terms use the registered scoreboard `sb` (see the optional feature for the exception). Each term is gated by dec_valid_i:
  - RAW: (rs1_re && rs1!=0 && sb[rs1]) || (rs2_re && rs2!=0 && sb[rs2])
  - WAW: wb_we && rd!=0 && sb[rd]
  - Load resource: dec_load_i && pending_loads==LSU_DEPTH
  - MDU resource: dec_mdu_req_i && mdu_busy
  - Fence drain: dec_fence_i && (pending_loads!=0 || mdu_busy)
- stall_o = OR of the stall terms. flush_i does not affect stall_o.
- issue_o = dec_valid_i && !stall_o && !flush_i.
- Load issue (issue_o && dec_load_i):
  - push dec_rd_addr_i, or 0 if !wb_we, into the FIFO tail
  - set sb[rd] if wb_we && rd!=0
  - pending_loads +1
- lsu_rsp_valid_i with FIFO non-empty: pop head, clear sb[head] (head!=0), pending_loads -1.
- Push and pop in the same cycle: occupancy unchanged, and a push into a full FIFO is legal if a pop occurs that cycle. The load-resource stall uses registered occupancy, so a full FIFO still stalls.
- lsu_rsp_valid_i with FIFO empty: no state change; spurious_rsp_o=1 next cycle.
- mdu_done_i with !mdu_busy: no state change; spurious_rsp_o=1 next cycle.
- MDU issue (issue_o && dec_mdu_req_i): mdu_busy<=1, mdu_rd<=rd, set sb[rd] if wb_we && rd!=0.
- mdu_done_i while busy: mdu_busy<=0, clear sb[mdu_rd].
- A same-cycle MDU done and new MDU issue cannot occur, because the MDU resource stall uses the registered busy.
- Set/clear collision on the same bit cannot occur, because of the WAW stall. Implement clear-then-set ordering regardless.
- Stores, branches, jal/jalr, ALU ops and illegal instructions (no load/mdu) never touch the scoreboard.
- flush_i never cancels in-flight ops; their responses still retire tags.
- The FIFO uses pointers of width $clog2(LSU_DEPTH), minimum 1, wrapping modulo LSU_DEPTH. Non-power-of-two depths wrap explicitly.
- lsu_rsp_rd_o = FIFO head entry; it equals 0 when the FIFO is empty.

Optional Feature:
MIRISCV_HAZARD_BYPASS_EN
- Defined: RAW and fence-drain terms use sb & ~clr_mask, where clr_mask is the set of bits cleared this cycle by lsu_rsp_valid_i or mdu_done_i. Pending-load and busy terms see the post-retire value in the same way. A dependent instruction then issues in the same cycle its producer writes back, assuming a regfile write-through/forward path.
  - The WAW term always uses registered sb.
  - The resource terms always use registered counts.
- Undefined: all terms use registered state; a dependent instruction issues one cycle after writeback.

Test Plan:
- Load x5, then add x6,x5,x1 next cycle → stall_o=1 until lsu_rsp_valid_i. issue_o=1 in the cycle after the response (same cycle with BYPASS_EN); scoreboard_o bit5 goes 1 then 0.
- LSU_DEPTH=2: three back-to-back loads to x1,x2,x3 → third stalls, pending_loads_o=2. One response with a simultaneous third issue is not allowed (registered full); the third issues the next cycle. Responses return lsu_rsp_rd_o=1,2,3 in order.
- mul x7 then div x8 → second stalls while mdu_busy_o=1. After mdu_done_i, div issues; mdu_rd_o=8.
- Load to x0 followed by a use of x0 → no stall. FIFO entry tag is 0; scoreboard_o stays 0.
- Fence with one load outstanding → stall_o=1 until the response, then issue_o=1.
- flush_i=1 with a hazard-free load → issue_o=0, no push. Response with empty FIFO → spurious_rsp_o pulses once. Assert arstn_i mid-flight → all outputs return to reset values asynchronously.
